arp_ctrl: RTL and testbench
===========================

# arp_ctrl

Sequencing controller for the ARP engine on the GMII transmit clock. Answers incoming ARP requests addressed to the board, issues ARP requests to resolve a target IP with timed retries, and holds the resolved MAC for the UDP/video path. It drives the ARP TX command port (`arp_tx_en`/`arp_tx_type`/`des_mac`/`des_ip`) and consumes the ARP RX results; RX strobes arrive already synchronized to `clk`.

## Interface
- `RETRY_CYCLES`, default 125_000_000: reply wait time per request, in clk cycles (1 s at 125 MHz).
- `MAX_RETRY`, default 3: total request transmissions before failure; must be ≥1.
- `clk` in 1: gmii_tx_clk domain. One clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `start_req` in 1: one-cycle pulse; begin resolution of `target_ip`.
- `target_ip` in 32: IP to resolve; sampled when `start_req` is accepted.
- `arp_rx_done` in 1: one-cycle strobe; a valid ARP frame was received.
- `arp_rx_type` in 1: 0 = request, 1 = reply; valid with `arp_rx_done`.
- `src_mac` in 48: sender MAC; valid with `arp_rx_done`.
- `src_ip` in 32: sender IP; valid with `arp_rx_done`.
- `tx_done` in 1: one-cycle strobe; the ARP frame has been sent.
- `arp_tx_en` out 1: one-cycle TX start pulse.
- `arp_tx_type` out 1: 0 = request, 1 = reply.
- `des_mac` out 48: TX destination MAC.
- `des_ip` out 32: TX destination IP.
- `busy` out 1: high in any state other than IDLE.
- `resolved` out 1: level; `resolved_mac` is valid.
- `resolved_mac` out 48: MAC learned for the last resolved `target_ip`.
- `fail` out 1: one-cycle pulse; retries are exhausted.

## Operation
- States: IDLE, RPLY_TX, REQ_TX, WAIT_REPLY.
- **Capture, in all states:**
  - `arp_rx_done && !arp_rx_type` sets `rply_pend` and stores `src_mac`/`src_ip` into reply registers.
  - A second request before service overwrites the stored pair. Only the latest request is answered.
- **start_req:**
  - Accepted only when no resolution is in progress, i.e. state is IDLE or RPLY_TX entered from IDLE.
  - Acceptance sets `req_pend`, latches `target_ip`, clears `resolved`, and clears the retry count.
  - Ignored otherwise.
- **IDLE priority:** `rply_pend` first, then `req_pend`.
- **Entering RPLY_TX:**
  - `arp_tx_en`=1 for one cycle, `arp_tx_type`=1.
  - `des_mac`/`des_ip` = stored reply pair; `rply_pend` clears.
  - On `tx_done`, return to the state that was left: IDLE or WAIT_REPLY.
- **Entering REQ_TX:**
  - `arp_tx_en`=1 for one cycle, `arp_tx_type`=0.
  - `des_mac`=48'hff_ff_ff_ff_ff_ff, `des_ip`=latched target; `req_pend` clears; retry count +1.
  - On `tx_done`, go to WAIT_REPLY with the timer cleared.
- **WAIT_REPLY:**
  - Timer increments each cycle.
  - Match when `arp_rx_done && arp_rx_type && src_ip==target`: `resolved_mac`←`src_mac`, `resolved`←1, go to IDLE.
  - If `rply_pend` and no match in the same cycle: go to RPLY_TX. The timer freezes and resumes on return.
  - Timer == RETRY_CYCLES-1 with no match:
    - If retry count < MAX_RETRY, go to REQ_TX.
    - Else pulse `fail` and go to IDLE; `resolved` stays 0.
- Replies outside WAIT_REPLY, or with a non-matching IP, are ignored.
- `des_mac`/`des_ip`/`arp_tx_type` hold their values from the `arp_tx_en` pulse until the next pulse.
- Widths:
  - Timer is `$clog2(RETRY_CYCLES)` bits.
  - Retry counter is `$clog2(MAX_RETRY+1)` bits.
  - Comparisons are unsigned; no wrap-around is possible.

## Timing
- **Reset values:**
  - `arp_tx_en`, `arp_tx_type`, `busy`, `resolved`, `fail` = 0.
  - `des_mac` = 48'hff_ff_ff_ff_ff_ff, `des_ip` = 0, `resolved_mac` = 0.
  - State IDLE; pend flags, timer and counter cleared.
- Reset mid-frame returns to IDLE immediately; the pending frame is abandoned.
- All outputs are registered.
- Latency from IDLE:
  - `arp_rx_done` (request) at cycle N → `arp_tx_en` at N+2.
  - `start_req` at N → `arp_tx_en` at N+2.
- `tx_done` is honoured only in RPLY_TX/REQ_TX; elsewhere it is ignored.
- A match and a timer expiry in the same cycle: the match wins.
- A match and a request capture in the same cycle: resolve first, then reply from IDLE.

## Test plan
- **Reply service:** IDLE; rx request from 192.168.1.102 / MAC 11:22:33:44:55:66 → at N+2, `arp_tx_en` pulse with type 1, `des_ip`=C0A80166, `des_mac`=112233445566; after `tx_done`, `busy`=0.
- **Resolve:** `start_req`, target C0A80166 → request pulse, type 0, `des_mac` all-ones. Then `tx_done`, then rx reply (type 1, C0A80166, MAC AA..) after 50 cycles → `resolved`=1, `resolved_mac`=AA.., single TX only.
- **Retry/fail:** RETRY_CYCLES=100, MAX_RETRY=3, no reply → exactly 3 request pulses, each 100 cycles after the preceding `tx_done`. Then one `fail` pulse; `resolved`=0.
- **Ignored reply:** in WAIT_REPLY, a reply from C0A80167 → no resolve; the retry still fires at the timeout.
- **Interleave:** an rx request arrives in WAIT_REPLY at timer=40 → reply TX sent, timer resumes from 40; the later matching reply resolves.
- **Reset:** `rst_n` low during REQ_TX before `tx_done` → all outputs at reset values; a later `tx_done` causes nothing.

Source files
------------

// File: rtl/arp_ctrl_if.sv
// ARP engine command/result bundle: TX command port toward the frame builder
// and the already-synchronized RX result strobes coming back from the parser.
interface arp_ctrl_if;
    logic        arp_rx_done;
    logic        arp_rx_type;
    logic [47:0] src_mac;
    logic [31:0] src_ip;
    logic        tx_done;
    logic        arp_tx_en;
    logic        arp_tx_type;
    logic [47:0] des_mac;
    logic [31:0] des_ip;

    modport master (
        input  arp_rx_done, arp_rx_type, src_mac, src_ip, tx_done,
        output arp_tx_en, arp_tx_type, des_mac, des_ip
    );

    modport slave (
        output arp_rx_done, arp_rx_type, src_mac, src_ip, tx_done,
        input  arp_tx_en, arp_tx_type, des_mac, des_ip
    );
endinterface

// File: rtl/arp_ctrl.sv
// ARP sequencing controller: answers requests addressed to the board and
// resolves a target IP with timed request retries.
module arp_ctrl #(
    parameter int RETRY_CYCLES = 125_000_000,
    parameter int MAX_RETRY    = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_req,
    input  logic [31:0] target_ip,
    arp_ctrl_if.master  arp,
    output logic        busy,
    output logic        resolved,
    output logic [47:0] resolved_mac,
    output logic        fail
);
    // state        | meaning
    // S_IDLE       | nothing in flight; serve rply_pend, then req_pend
    // S_RPLY_TX    | ARP reply being sent; returns to IDLE or WAIT_REPLY
    // S_REQ_TX     | broadcast ARP request being sent
    // S_WAIT_REPLY | reply timer running for the latched target

    localparam int TW = (RETRY_CYCLES > 1) ? $clog2(RETRY_CYCLES) : 1;
    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam logic [TW-1:0] TMR_LOAD  = TW'(RETRY_CYCLES - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
    localparam logic [47:0]   BCAST_MAC = 48'hff_ff_ff_ff_ff_ff;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RPLY_TX,
        S_REQ_TX,
        S_WAIT_REPLY
    } state_t;

    state_t        state, state_nxt;
    logic          ret_wait, ret_wait_nxt;
    logic          rply_pend, req_pend;
    logic [47:0]   rply_mac;
    logic [31:0]   rply_ip;
    logic [31:0]   tgt_ip;
    logic [TW-1:0] tmr;
    logic [RW-1:0] retry_cnt;

    logic rx_req, rx_match, accept;
    logic go_rply, go_req, do_match, do_fail, tmr_load, tmr_dec;

    assign rx_req   = arp.arp_rx_done && !arp.arp_rx_type;
    assign rx_match = arp.arp_rx_done && arp.arp_rx_type && (arp.src_ip == tgt_ip);
    // A reply detour taken from IDLE still counts as "no resolution in progress".
    assign accept   = start_req && !req_pend &&
                      ((state == S_IDLE) || ((state == S_RPLY_TX) && !ret_wait));

    always_comb begin
        state_nxt    = state;
        ret_wait_nxt = ret_wait;
        go_rply      = 1'b0;
        go_req       = 1'b0;
        do_match     = 1'b0;
        do_fail      = 1'b0;
        tmr_load     = 1'b0;
        tmr_dec      = 1'b0;
        case (state)
            S_IDLE: begin
                if (rply_pend) begin
                    state_nxt    = S_RPLY_TX;
                    go_rply      = 1'b1;
                    ret_wait_nxt = 1'b0;
                end else if (req_pend) begin
                    state_nxt = S_REQ_TX;
                    go_req    = 1'b1;
                end
            end
            S_RPLY_TX: begin
                if (arp.tx_done) state_nxt = ret_wait ? S_WAIT_REPLY : S_IDLE;
            end
            S_REQ_TX: begin
                if (arp.tx_done) begin
                    state_nxt = S_WAIT_REPLY;
                    tmr_load  = 1'b1;
                end
            end
            S_WAIT_REPLY: begin
                if (rx_match) begin
                    state_nxt = S_IDLE;
                    do_match  = 1'b1;
                end else if (rply_pend) begin
                    // Timer holds its value across the reply detour.
                    state_nxt    = S_RPLY_TX;
                    go_rply      = 1'b1;
                    ret_wait_nxt = 1'b1;
                end else if (tmr == '0) begin
                    if (retry_cnt < RETRY_MAX) begin
                        state_nxt = S_REQ_TX;
                        go_req    = 1'b1;
                    end else begin
                        state_nxt = S_IDLE;
                        do_fail   = 1'b1;
                    end
                end else begin
                    tmr_dec = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= S_IDLE;
            ret_wait        <= 1'b0;
            rply_pend       <= 1'b0;
            req_pend        <= 1'b0;
            rply_mac        <= '0;
            rply_ip         <= '0;
            tgt_ip          <= '0;
            tmr             <= '0;
            retry_cnt       <= '0;
            arp.arp_tx_en   <= 1'b0;
            arp.arp_tx_type <= 1'b0;
            arp.des_mac     <= BCAST_MAC;
            arp.des_ip      <= '0;
            busy            <= 1'b0;
            resolved        <= 1'b0;
            resolved_mac    <= '0;
            fail            <= 1'b0;
        end else begin
            state         <= state_nxt;
            ret_wait      <= ret_wait_nxt;
            busy          <= (state_nxt != S_IDLE);
            arp.arp_tx_en <= go_rply || go_req;
            fail          <= do_fail;

            // A capture landing on the service edge stays pending for another reply.
            if (rx_req) begin
                rply_pend <= 1'b1;
                rply_mac  <= arp.src_mac;
                rply_ip   <= arp.src_ip;
            end else if (go_rply) begin
                rply_pend <= 1'b0;
            end

            if (go_rply) begin
                arp.arp_tx_type <= 1'b1;
                arp.des_mac     <= rply_mac;
                arp.des_ip      <= rply_ip;
            end else if (go_req) begin
                arp.arp_tx_type <= 1'b0;
                arp.des_mac     <= BCAST_MAC;
                arp.des_ip      <= tgt_ip;
            end

            if (accept) begin
                req_pend  <= 1'b1;
                tgt_ip    <= target_ip;
                resolved  <= 1'b0;
                retry_cnt <= '0;
            end else if (go_req) begin
                req_pend  <= 1'b0;
                retry_cnt <= retry_cnt + RW'(1);
            end

            if (do_match) begin
                resolved     <= 1'b1;
                resolved_mac <= arp.src_mac;
            end

            if (tmr_load) tmr <= TMR_LOAD;
            else if (tmr_dec) tmr <= tmr - TW'(1);
        end
    end
endmodule

// File: tb/tb_arp_ctrl.sv
// Directed-sequence bench for arp_ctrl with randomized addresses and delays;
// expected TX pulses and their cycles are derived from the protocol rules.
module tb_arp_ctrl;
    localparam int RETRY = 100;
    localparam int MAXR  = 3;
    localparam logic [47:0] BCAST = 48'hff_ff_ff_ff_ff_ff;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_req = 1'b0;
    logic [31:0] target_ip = '0;
    logic        busy, resolved, fail;
    logic [47:0] resolved_mac;

    arp_ctrl_if arp();

    arp_ctrl #(.RETRY_CYCLES(RETRY), .MAX_RETRY(MAXR)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_req    (start_req),
        .target_ip    (target_ip),
        .arp          (arp),
        .busy         (busy),
        .resolved     (resolved),
        .resolved_mac (resolved_mac),
        .fail         (fail)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int tx_cnt = 0;
    int fail_cnt = 0;
    int n_tests = 0;
    int n_fail = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (arp.arp_tx_en === 1'b1) tx_cnt <= tx_cnt + 1;
        if (fail === 1'b1) fail_cnt <= fail_cnt + 1;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    function automatic logic [47:0] rnd48();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[47:0];
    endfunction

    task automatic pulse_rx(input logic ty, input logic [47:0] mac, input logic [31:0] ip);
        arp.arp_rx_done = 1'b1;
        arp.arp_rx_type = ty;
        arp.src_mac     = mac;
        arp.src_ip      = ip;
        tick();
        arp.arp_rx_done = 1'b0;
    endtask

    task automatic pulse_tx_done();
        arp.tx_done = 1'b1;
        tick();
        arp.tx_done = 1'b0;
    endtask

    task automatic pulse_start(input logic [31:0] ip);
        start_req = 1'b1;
        target_ip = ip;
        tick();
        start_req = 1'b0;
    endtask

    // Waits (bounded) for the next TX pulse and checks its content and cycle.
    task automatic expect_tx(input string tag, input logic ty, input logic [47:0] mac,
                             input logic [31:0] ip, input int exp_cyc);
        int n = 0;
        while (arp.arp_tx_en !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        chk({tag, " tx_en"}, arp.arp_tx_en, 1'b1);
        chk({tag, " cycle"}, cyc, exp_cyc);
        chk({tag, " type"}, arp.arp_tx_type, ty);
        chk({tag, " des_mac"}, arp.des_mac, mac);
        chk({tag, " des_ip"}, arp.des_ip, ip);
    endtask

    task automatic expect_fail(input string tag, input int exp_cyc);
        int n = 0;
        while (fail !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
        chk({tag, " fail"}, fail, 1'b1);
        chk({tag, " cycle"}, cyc, exp_cyc);
    endtask

    // Next request is due once the timer has counted the remaining
    // RETRY - timer_at_resume wait cycles; the registered pulse shows one cycle later.
    function automatic int retry_due(input int resume_cyc, input int timer_at_resume);
        return resume_cyc + (RETRY - timer_at_resume);
    endfunction

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " tx_en"}, arp.arp_tx_en, 1'b0);
        chk({tag, " tx_type"}, arp.arp_tx_type, 1'b0);
        chk({tag, " des_mac"}, arp.des_mac, BCAST);
        chk({tag, " des_ip"}, arp.des_ip, 32'h0);
        chk({tag, " busy"}, busy, 1'b0);
        chk({tag, " resolved"}, resolved, 1'b0);
        chk({tag, " resolved_mac"}, resolved_mac, 48'h0);
        chk({tag, " fail"}, fail, 1'b0);
    endtask

    initial begin
        logic [47:0] mac, mac_b, rmac;
        logic [31:0] ip, ip_b, tgt;
        int s, t, r, c, k, exp_c, tx0, f0;

        arp.arp_rx_done = 1'b0;
        arp.arp_rx_type = 1'b0;
        arp.src_mac     = '0;
        arp.src_ip      = '0;
        arp.tx_done     = 1'b0;

        ticks(3);
        chk_reset_outputs("por");
        rst_n = 1'b1;
        ticks(2);

        // Reply service: fixed pair first, then a random one
        for (int i = 0; i < 2; i++) begin
            mac = (i == 0) ? 48'h11_22_33_44_55_66 : rnd48();
            ip  = (i == 0) ? 32'hC0A8_0166 : $urandom();
            s = cyc;
            pulse_rx(1'b0, mac, ip);
            expect_tx("rply", 1'b1, mac, ip, s + 2);
            ticks(int'($urandom_range(0, 4)));
            pulse_tx_done();
            chk("rply busy after tx_done", busy, 1'b0);
            ticks(3);
        end

        // Two requests during a reply: only the latest pair is answered
        tx0 = tx_cnt;
        s = cyc;
        pulse_rx(1'b0, rnd48(), $urandom());
        expect_tx("rply pre", 1'b1, arp.src_mac, arp.src_ip, s + 2);
        mac = rnd48();   ip = $urandom();
        mac_b = rnd48(); ip_b = $urandom();
        pulse_rx(1'b0, mac, ip);
        pulse_rx(1'b0, mac_b, ip_b);
        t = cyc;
        pulse_tx_done();
        expect_tx("rply latest", 1'b1, mac_b, ip_b, t + 2);
        pulse_tx_done();
        ticks(10);
        chk("overwrite tx count", tx_cnt - tx0, 2);
        chk("overwrite busy", busy, 1'b0);

        // Resolve; an early matching reply during REQ_TX must be ignored
        tgt  = 32'hC0A8_0166;
        rmac = {8'hAA, rnd48() >> 8};
        tx0 = tx_cnt; f0 = fail_cnt;
        s = cyc;
        pulse_start(tgt);
        expect_tx("req", 1'b0, BCAST, tgt, s + 2);
        chk("req busy", busy, 1'b1);
        pulse_rx(1'b1, rnd48(), tgt);
        pulse_tx_done();
        ticks(49);
        chk("resolve before reply", resolved, 1'b0);
        pulse_rx(1'b1, rmac, tgt);
        chk("resolve flag", resolved, 1'b1);
        chk("resolve mac", resolved_mac, rmac);
        chk("resolve busy", busy, 1'b0);
        ticks(RETRY + 20);
        chk("resolve tx count", tx_cnt - tx0, 1);
        chk("resolve no fail", fail_cnt - f0, 0);
        chk("resolve flag holds", resolved, 1'b1);

        // Retry/fail with a non-matching reply and an ignored start_req
        tgt = $urandom() | 32'h1;
        tx0 = tx_cnt; f0 = fail_cnt;
        s = cyc;
        pulse_start(tgt);
        chk("retry start clears resolved", resolved, 1'b0);
        exp_c = s + 2;
        t = 0;
        for (int i = 0; i < MAXR; i++) begin
            expect_tx($sformatf("retry%0d", i), 1'b0, BCAST, tgt, exp_c);
            ticks(int'($urandom_range(0, 3)));
            t = cyc;
            pulse_tx_done();
            exp_c = retry_due(t + 1, 0);
            if (i == 0) begin
                ticks(10);
                pulse_rx(1'b1, rnd48(), tgt ^ 32'h1);
                ticks(5);
                pulse_start(~tgt);
                chk("ignored reply", resolved, 1'b0);
            end
        end
        expect_fail("fail", exp_c);
        tick();
        chk("fail one cycle", fail, 1'b0);
        chk("fail resolved", resolved, 1'b0);
        chk("fail busy", busy, 1'b0);
        ticks(RETRY + 20);
        chk("fail tx count", tx_cnt - tx0, MAXR);
        chk("fail pulse count", fail_cnt - f0, 1);

        // Interleaved reply at timer=40, frozen timer, then a match on the expiry cycle
        tgt  = $urandom();
        rmac = rnd48();
        mac  = rnd48();
        ip   = $urandom();
        tx0 = tx_cnt; f0 = fail_cnt;
        s = cyc;
        pulse_start(tgt);
        expect_tx("ilv req", 1'b0, BCAST, tgt, s + 2);
        ticks(int'($urandom_range(0, 3)));
        pulse_tx_done();
        ticks(40);
        c = cyc;
        pulse_rx(1'b0, mac, ip);
        expect_tx("ilv rply", 1'b1, mac, ip, c + 2);
        k = 41;
        ticks(int'($urandom_range(0, 5)));
        r = cyc;
        pulse_tx_done();
        chk("ilv back in wait busy", busy, 1'b1);
        expect_tx("ilv retry", 1'b0, BCAST, tgt, retry_due(r + 1, k));
        ticks(int'($urandom_range(0, 3)));
        pulse_tx_done();
        ticks(RETRY - 1);
        pulse_rx(1'b1, rmac, tgt);
        chk("ilv match at expiry", resolved, 1'b1);
        chk("ilv resolved mac", resolved_mac, rmac);
        ticks(RETRY + 20);
        chk("ilv tx count", tx_cnt - tx0, 3);
        chk("ilv no fail", fail_cnt - f0, 0);

        // Reset during REQ_TX; a late tx_done must do nothing
        tgt = $urandom();
        s = cyc;
        pulse_start(tgt);
        expect_tx("rst req", 1'b0, BCAST, tgt, s + 2);
        tick();
        #2 rst_n = 1'b0;
        #1 chk_reset_outputs("midrst");
        tick();
        rst_n = 1'b1;
        tick();
        tx0 = tx_cnt; f0 = fail_cnt;
        pulse_tx_done();
        ticks(RETRY + 20);
        chk("rst late tx_done count", tx_cnt - tx0, 0);
        chk("rst busy", busy, 1'b0);
        chk("rst no fail", fail_cnt - f0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
